keypad_scan: RTL and testbench
==============================

# keypad_scan

Upstream input stage of the calculator: scans a 4x4 matrix keypad, synchronizes and debounces the raw row lines, and emits one single-cycle `key_valid` pulse per physical key press together with a 4-bit key code. `key_valid` drives the `num` input of the downstream press counter `cnt`. `key_code` feeds the operand/operator decode logic.

## Interface

Parameters:
- `SCAN_DIV`, default 4: clock cycles each column stays driven (dwell). Must be ≥ 3 to cover synchronizer latency.
- `DEB_CNT`, default 3: number of consecutive matching samples required to accept a press or a release. Must be ≥ 1.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_key` input 1: asynchronous, active-low reset.
- `row_in` input 4: raw keypad rows, active-high, asynchronous to `clk`.
- `col_out` output 4: one-hot column drive.
- `key_code` output 4: last accepted key, encoded as {row[1:0], col[1:0]}.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high while the accepted key remains pressed.

## Operation

- `row_in` passes through a 2-flop synchronizer (`row_s`). All decisions use `row_s` only.
- A dwell counter runs 0..SCAN_DIV-1. The sample point is the cycle where the counter equals SCAN_DIV-1.
- When multiple rows are set, the selected row is the lowest set bit of `row_s`.
- States:
  - **SCAN**: at each sample point, if `row_s` is 0, rotate `col_out` (0001→0010→0100→1000→0001). If nonzero, latch the column index and the selected row, set the match count to 1 and go to DEBOUNCE. `col_out` is frozen from this point.
  - **DEBOUNCE**: at each sample point, compare the selected row against the latched row.
    - If they match, increment the count. When the count reaches DEB_CNT: load `key_code`, pulse `key_valid` and go to HELD.
    - On a mismatch (including zero), rotate to the next column and return to SCAN.
    - If DEB_CNT=1, the press is accepted at the detection sample.
  - **HELD**: `key_held`=1 and `col_out` stays frozen.
    - At each sample point, if `row_s`=0, increment the release count; otherwise clear it.
    - When the release count reaches DEB_CNT: clear `key_held`, rotate to the next column and go to SCAN.
    - There is no auto-repeat.
- `key_code` holds its value until the next accepted press.
- A second key pressed during HELD is ignored. It is detected only after release, on a later scan.

## Timing

- Reset values: `col_out`=4'b0001, `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, all counters 0.
- Reset is asynchronous on assertion. After deassertion, scanning resumes from column 0 on the next cycle.
- `key_valid` and the `key_code` update are registered. Both appear in the cycle after the accepting sample point.
- `key_valid` is high for exactly 1 cycle. `key_held` rises in that same cycle.
- Press-to-pulse latency, with the key stable and its column active: first sample point, plus (DEB_CNT-1)·SCAN_DIV cycles, plus 1 cycle.
- Column rotation takes effect in the cycle after the sample point, so the dwell counter restarts aligned with the new column.
- Reset during DEBOUNCE or HELD:
  - Any pending pulse is aborted.
  - The key remaining pressed after reset is re-detected as a new press; this is intended behaviour.

## Structure

- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD);
  - the constants NUM_ROWS=4 and NUM_COLS=4;
  - the key-code width 4;
  - the reset column pattern 4'b0001.
- Sub-module `sync2`: a parameterized-width two-flop synchronizer with async active-low reset to 0. It is instantiated once, at width 4.
- Top level contains the dwell counter, the debounce/release counters, the FSM and the output registers.

## Test plan

The bench keypad model drives `row_in[r] = col_out[c]` for each pressed key (r,c). All scenarios use SCAN_DIV=4 and DEB_CNT=3.

- **Reset:** `rst_key`=0 for 3 cycles → `col_out`=0001, `key_code`=0, `key_valid`=0, `key_held`=0. After release, `col_out` rotates every 4 cycles.
- **Clean press:** key (1,2) held for 200 cycles → exactly one `key_valid` pulse, with `key_code`=4'd6. `key_held`=1 until 3 zero samples after release, then scanning resumes at column 3.
- **Bounce:** key (2,0) present for only 1 sample point, then released → no `key_valid`, and scanning resumes at column 1.
- **Multi-key:** keys (1,3) and (3,3) pressed together → one pulse, with `key_code`=4'd7 (lowest row wins).
- **Repeated presses:** five press/release cycles of key (0,1), each held for 60 cycles → five `key_valid` pulses, all with `key_code`=4'd1. The downstream `cnt` sees five `num` pulses.
- **Reset in HELD:** assert `rst_key` while `key_held`=1 → outputs return immediately to their reset values. With the key still pressed, a new pulse arrives after re-detection.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   scanStateT - scanner FSM states (SCAN, DEBOUNCE, HELD)
//   NUM_ROWS / NUM_COLS / KEY_W - matrix geometry and key-code width
//   COL_RESET  - column drive pattern out of reset
//   lowestSet  - index of the lowest set bit of a 4-bit vector
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scanStateT;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b0001;

    // Lowest set bit wins; returns 0 for an all-zero input, callers
    // qualify with a separate "any bit set" test.
    function automatic logic [1:0] lowestSet(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// sync2: parameterized-width two-flop synchronizer.
//   clk  - destination clock
//   rstN - asynchronous active-low reset, clears both stages to 0
//   d    - asynchronous input bus
//   q    - synchronized output bus (two cycles of latency)
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with synchronizer and debounce.
//   clk       - single clock, rising edge
//   rst_key   - asynchronous active-low reset
//   row_in    - raw active-high row lines, asynchronous to clk
//   col_out   - one-hot column drive
//   key_code  - last accepted key as {row[1:0], col[1:0]}
//   key_valid - single-cycle pulse per accepted press
//   key_held  - high while the accepted key stays pressed
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,   // dwell cycles per column, >= 3
    parameter int DEB_CNT  = 3    // consecutive samples to accept, >= 1
) (
    input  logic                clk,
    input  logic                rst_key,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_CNT + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CNT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [NUM_ROWS-1:0] rowS;
    logic [DW-1:0]       dwellCnt;
    logic [CW-1:0]       matchCnt;
    logic [CW-1:0]       relCnt;
    logic [1:0]          latchRow;
    logic [1:0]          latchCol;
    scanStateT           state;

    logic                samplePt;
    logic                rowHit;
    logic [1:0]          selRow;
    logic [NUM_COLS-1:0] colNext;
    logic [CW-1:0]       matchInc;
    logic [CW-1:0]       relInc;

    sync2 #(.WIDTH(NUM_ROWS)) uSync (
        .clk  (clk),
        .rstN (rst_key),
        .d    (row_in),
        .q    (rowS)
    );

    assign samplePt = (dwellCnt == DWELL_LAST);
    assign rowHit   = |rowS;
    assign selRow   = lowestSet(rowS);
    assign colNext  = {col_out[NUM_COLS-2:0], col_out[NUM_COLS-1]};
    assign matchInc = matchCnt + CNT_ONE;
    assign relInc   = relCnt + CNT_ONE;

    // Dwell counter free-runs; since every column change happens on a
    // sample-point edge, the counter wrap keeps each column's dwell aligned.
    always_ff @(posedge clk or negedge rst_key) begin
        if (!rst_key) begin
            dwellCnt <= '0;
        end else begin
            dwellCnt <= samplePt ? '0 : dwellCnt + DWELL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_key) begin
        if (!rst_key) begin
            state     <= SCAN;
            col_out   <= COL_RESET;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            matchCnt  <= '0;
            relCnt    <= '0;
            latchRow  <= '0;
            latchCol  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (samplePt) begin
                case (state)
                    SCAN: begin
                        if (!rowHit) begin
                            col_out <= colNext;
                        end else begin
                            // Column is frozen from here until release or mismatch.
                            latchRow <= selRow;
                            latchCol <= lowestSet(col_out);
                            if (DEB_CNT == 1) begin
                                key_code  <= {selRow, lowestSet(col_out)};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                matchCnt  <= '0;
                                relCnt    <= '0;
                                state     <= HELD;
                            end else begin
                                matchCnt <= CNT_ONE;
                                state    <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (rowHit && (selRow == latchRow)) begin
                            if (matchInc == DEB_LAST) begin
                                key_code  <= {latchRow, latchCol};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                matchCnt  <= '0;
                                relCnt    <= '0;
                                state     <= HELD;
                            end else begin
                                matchCnt <= matchInc;
                            end
                        end else begin
                            matchCnt <= '0;
                            col_out  <= colNext;
                            state    <= SCAN;
                        end
                    end
                    HELD: begin
                        // Any row activity (even another key) keeps the hold alive.
                        if (!rowHit) begin
                            if (relInc == DEB_LAST) begin
                                relCnt   <= '0;
                                key_held <= 1'b0;
                                col_out  <= colNext;
                                state    <= SCAN;
                            end else begin
                                relCnt <= relInc;
                            end
                        end else begin
                            relCnt <= '0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed bench for keypad_scan with a
// behavioural keypad and an integer-level reference model of the scanner.
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic       clk;
    logic       rst_key;
    logic [3:0] rowIn;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;   // pressed[r][c]

    int tests;
    int fails;
    int pulses;
    logic [3:0] lastCode;

    // reference model state
    int   mCol, mCode, mCandRow, mMatches, mRel, mCyc;
    bit   mValid, mHeld, mInCand;
    logic [3:0] s1, s2;

    keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DEB)) dut (
        .clk       (clk),
        .rst_key   (rst_key),
        .row_in    (rowIn),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key shorts its column drive onto its row line.
    always_comb begin
        rowIn = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && col_out[c]) rowIn[r] = 1'b1;
    end

    task automatic modelAccept();
        mCode    = mCandRow * 4 + mCol;
        mValid   = 1;
        mHeld    = 1;
        mInCand  = 0;
        mMatches = 0;
        mRel     = 0;
    endtask

    // Predicts the scanner's outputs after the coming rising edge.
    task automatic modelStep();
        int lo;
        if (!rst_key) begin
            mCol = 0; mCode = 0; mValid = 0; mHeld = 0; mInCand = 0;
            mCandRow = 0; mMatches = 0; mRel = 0; mCyc = 0; s1 = '0; s2 = '0;
            return;
        end
        mValid = 0;
        if (mCyc % SD == SD - 1) begin
            lo = -1;
            for (int r = 3; r >= 0; r--) if (s2[r]) lo = r;
            if (mHeld) begin
                if (lo < 0) mRel++; else mRel = 0;
                if (mRel == DEB) begin
                    mHeld = 0; mRel = 0; mCol = (mCol + 1) % 4;
                end
            end else if (!mInCand) begin
                if (lo < 0) mCol = (mCol + 1) % 4;
                else begin
                    mInCand = 1; mCandRow = lo; mMatches = 1;
                    if (mMatches == DEB) modelAccept();
                end
            end else if (lo == mCandRow) begin
                mMatches++;
                if (mMatches == DEB) modelAccept();
            end else begin
                mInCand = 0; mCol = (mCol + 1) % 4;
            end
        end
        mCyc++;
        s2 = s1;
        s1 = rowIn;
    endtask

    // One clock: model the edge, let the DUT take it, compare on the falling edge.
    task automatic tick();
        logic [9:0] obs, expv;
        logic [3:0] expCol;
        #1;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        expCol = 4'b0001 << mCol;
        expv = {expCol, 4'(mCode), mValid, mHeld};
        obs  = {col_out, key_code, key_valid, key_held};
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("FAIL model t=%0t {col,code,valid,held} got %b expected %b", $time, obs, expv);
        end
        if (key_valid === 1'b1) begin
            pulses++;
            lastCode = key_code;
        end
    endtask

    task automatic waitRelease(input string name);
        int n = 0;
        while (key_held !== 1'b0 && n < 200) begin tick(); n++; end
        tests++;
        if (key_held !== 1'b0) begin
            fails++;
            $display("FAIL %s release timeout key_held=%b expected 0", name, key_held);
        end
    endtask

    task automatic test_reset();
        pressed = '0;
        rst_key = 1'b0;
        repeat (3) tick();
        tests++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values got %b expected 0001_0000_0_0", {col_out, key_code, key_valid, key_held});
        end
        rst_key = 1'b1;
        repeat (4) tick();
        tests++;
        if (col_out !== 4'b0010) begin
            fails++;
            $display("FAIL reset_rotate1 col_out=%b expected 0010", col_out);
        end
        repeat (4) tick();
        tests++;
        if (col_out !== 4'b0100) begin
            fails++;
            $display("FAIL reset_rotate2 col_out=%b expected 0100", col_out);
        end
    endtask

    task automatic test_clean_press();
        pulses = 0;
        pressed[1][2] = 1'b1;
        repeat (200) tick();
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL clean_pulses got %0d expected 1", pulses);
        end
        tests++;
        if (lastCode !== 4'd6) begin
            fails++;
            $display("FAIL clean_code got %0d expected 6", lastCode);
        end
        tests++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL clean_held got %b expected 1", key_held);
        end
        pressed = '0;
        waitRelease("clean");
        tests++;
        if (col_out !== 4'b1000) begin
            fails++;
            $display("FAIL clean_resume col_out=%b expected 1000", col_out);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] prev;
        int n = 0;
        pressed = '0;
        prev = col_out;
        // Align to the first cycle of column 0's dwell.
        while (!(col_out === 4'b0001 && prev !== 4'b0001) && n < 64) begin
            prev = col_out; tick(); n++;
        end
        tests++;
        if (col_out !== 4'b0001) begin
            fails++;
            $display("FAIL bounce_align col_out=%b expected 0001", col_out);
        end
        pulses = 0;
        pressed[2][0] = 1'b1;
        repeat (SD) tick();
        pressed = '0;
        repeat (SD) tick();
        tests++;
        if (col_out !== 4'b0010) begin
            fails++;
            $display("FAIL bounce_resume col_out=%b expected 0010", col_out);
        end
        repeat (8) tick();
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL bounce_pulses got %0d expected 0", pulses);
        end
    endtask

    task automatic test_multi_key();
        pulses = 0;
        pressed = '0;
        pressed[1][3] = 1'b1;
        pressed[3][3] = 1'b1;
        repeat (100) tick();
        pressed = '0;
        waitRelease("multi");
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL multi_pulses got %0d expected 1", pulses);
        end
        tests++;
        if (lastCode !== 4'd7) begin
            fails++;
            $display("FAIL multi_code got %0d expected 7", lastCode);
        end
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            lastCode = 4'hF;
            pressed = '0;
            pressed[0][1] = 1'b1;
            repeat (60) tick();
            pressed = '0;
            waitRelease("repeat");
            repeat (8) tick();
            tests++;
            if (pulses != i + 1 || lastCode !== 4'd1) begin
                fails++;
                $display("FAIL repeat_%0d pulses=%0d code=%0d expected pulses=%0d code=1", i, pulses, lastCode, i + 1);
            end
        end
    endtask

    task automatic test_reset_held();
        int n = 0;
        pressed = '0;
        pressed[2][1] = 1'b1;
        while (key_held !== 1'b1 && n < 100) begin tick(); n++; end
        tests++;
        if (key_held !== 1'b1) begin
            fails++;
            $display("FAIL rsthold_reach key_held=%b expected 1", key_held);
        end
        rst_key = 1'b0;
        #1;
        tests++;
        if ({col_out, key_code, key_valid, key_held} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rsthold_async got %b expected 0001_0000_0_0", {col_out, key_code, key_valid, key_held});
        end
        repeat (2) tick();
        rst_key = 1'b1;
        pulses = 0;
        n = 0;
        while (pulses == 0 && n < 100) begin tick(); n++; end
        tests++;
        if (pulses != 1 || lastCode !== 4'd9) begin
            fails++;
            $display("FAIL rsthold_redetect pulses=%0d code=%0d expected pulses=1 code=9", pulses, lastCode);
        end
        pressed = '0;
        waitRelease("rsthold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            pressed = '0;
            pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 2) == 0)
                pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            repeat ($urandom_range(1, 70)) tick();
            pressed = '0;
            repeat ($urandom_range(1, 40)) tick();
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        pulses   = 0;
        lastCode = '0;
        pressed  = '0;
        rst_key  = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_back_to_back();
        test_reset_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
